// File: rtl/fp_pkg.sv
// Shared constants for the 13-bit float format (sign, 4-bit exponent, 8-bit fraction)
// used by int_to_fp, fp_adder and the hex display path.
package fp_pkg;

    localparam int INT_W  = 16;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;
    localparam int CNT_W  = 5;

    localparam logic [EXP_W-1:0]  EXP_MAX  = 4'hF;
    localparam logic [FRAC_W-1:0] FRAC_MAX = 8'hFF;

    // Exponent counter start value: one past the largest representable exponent
    localparam logic [CNT_W-1:0] E_START = 5'd16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        NORM = ST_NORM,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/int_to_fp_if.sv
// Handshake and result bundle of the integer-to-float converter.
// The master side requests conversions, the slave side is the converter.
interface int_to_fp_if;
    import fp_pkg::*;

    logic              start;
    logic [INT_W-1:0]  int_in;
    logic              ready;
    logic              done_tick;
    logic              sign_out;
    logic [EXP_W-1:0]  exp_out;
    logic [FRAC_W-1:0] frac_out;
    logic              sat_out;

    modport master (
        output start, int_in,
        input  ready, done_tick, sign_out, exp_out, frac_out, sat_out
    );

    modport slave (
        input  start, int_in,
        output ready, done_tick, sign_out, exp_out, frac_out, sat_out
    );

endinterface

// File: rtl/fp_round.sv
// Round-to-nearest (ties away from zero) of a normalized magnitude using guard bit m[7].
// Only instantiated when INT_TO_FP_ROUND_EN is defined.
module fp_round
    import fp_pkg::*;
(
    input  logic [8:0]        m_hi,
    input  logic [CNT_W-1:0]  e,
    output logic [FRAC_W-1:0] frac,
    output logic [EXP_W-1:0]  expn,
    output logic              sat
);

    logic [FRAC_W:0]  sum;
    logic [CNT_W-1:0] e_inc;

    // A carry out of the fraction renormalizes to 0x80 and bumps the exponent,
    // which saturates once it would leave the 4-bit range.
    always_comb begin
        sum   = {1'b0, m_hi[8:1]} + {{FRAC_W{1'b0}}, m_hi[0]};
        e_inc = e + 5'd1;
        frac  = sum[FRAC_W-1:0];
        expn  = e[EXP_W-1:0];
        sat   = 1'b0;
        if (sum[FRAC_W]) begin
            if (e_inc[CNT_W-1]) begin
                frac = FRAC_MAX;
                expn = EXP_MAX;
                sat  = 1'b1;
            end else begin
                frac = 8'h80;
                expn = e_inc[EXP_W-1:0];
            end
        end
    end

endmodule

// File: rtl/int_to_fp.sv
// Iterative 16-bit two's-complement to 13-bit float converter, one normalizing shift per cycle.
// Optional rounding of the fraction is enabled with the INT_TO_FP_ROUND_EN macro.
module int_to_fp
    import fp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    int_to_fp_if.slave bus
);

    state_t            state, state_next;
    logic [INT_W-1:0]  m, m_next;
    logic [CNT_W-1:0]  e, e_next;
    logic              sign_r, sign_next;
    logic              sign_q, sign_q_next;
    logic [EXP_W-1:0]  exp_q, exp_q_next;
    logic [FRAC_W-1:0] frac_q, frac_q_next;
    logic              sat_q, sat_q_next;

    logic [FRAC_W-1:0] norm_frac;
    logic [EXP_W-1:0]  norm_exp;
    logic              norm_sat;

`ifdef INT_TO_FP_ROUND_EN
    fp_round u_round (
        .m_hi (m[INT_W-1:7]),
        .e    (e),
        .frac (norm_frac),
        .expn (norm_exp),
        .sat  (norm_sat)
    );
`else
    assign norm_frac = m[INT_W-1 -: FRAC_W];
    assign norm_exp  = e[EXP_W-1:0];
    assign norm_sat  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m      <= '0;
            e      <= '0;
            sign_r <= 1'b0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            frac_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            m      <= m_next;
            e      <= e_next;
            sign_r <= sign_next;
            sign_q <= sign_q_next;
            exp_q  <= exp_q_next;
            frac_q <= frac_q_next;
            sat_q  <= sat_q_next;
        end
    end

    // Result registers only move on the NORM exit cycle, so they hold during normalization.
    // 0x8000 is the only input that is already normalized while e is still at its start value.
    always_comb begin
        state_next  = state;
        m_next      = m;
        e_next      = e;
        sign_next   = sign_r;
        sign_q_next = sign_q;
        exp_q_next  = exp_q;
        frac_q_next = frac_q;
        sat_q_next  = sat_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    sign_next  = bus.int_in[INT_W-1];
                    m_next     = bus.int_in[INT_W-1] ? (~bus.int_in + 16'd1) : bus.int_in;
                    e_next     = E_START;
                    state_next = NORM;
                end
            end
            NORM: begin
                if (m == '0) begin
                    sign_q_next = 1'b0;
                    exp_q_next  = '0;
                    frac_q_next = '0;
                    sat_q_next  = 1'b0;
                    state_next  = DONE;
                end else if (m[INT_W-1] && (e == E_START)) begin
                    sign_q_next = 1'b1;
                    exp_q_next  = EXP_MAX;
                    frac_q_next = FRAC_MAX;
                    sat_q_next  = 1'b1;
                    state_next  = DONE;
                end else if (m[INT_W-1]) begin
                    sign_q_next = sign_r;
                    exp_q_next  = norm_exp;
                    frac_q_next = norm_frac;
                    sat_q_next  = norm_sat;
                    state_next  = DONE;
                end else begin
                    m_next = m << 1;
                    e_next = e - 5'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ready     = (state == IDLE);
    assign bus.done_tick = (state == DONE);
    assign bus.sign_out  = sign_q;
    assign bus.exp_out   = exp_q;
    assign bus.frac_out  = frac_q;
    assign bus.sat_out   = sat_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: fixed vector table, protocol/reset sequences,
// and random operands checked against an arithmetic reference model.
module tb_int_to_fp;

    typedef struct {
        logic [15:0] din;
        logic        sign;
        logic [3:0]  expv;
        logic [7:0]  frac;
        logic        sat;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total_checks = 0;
    int   passed_checks = 0;

    int_to_fp_if intf ();

    int_to_fp dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check(input string name, input int act, input int expv);
        total_checks++;
        if (act == expv) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: normalize |x| so its top set bit lands in bit 15; exponent is that bit's position + 1
    task automatic refModel(input logic [15:0] x, output logic sign, output logic [3:0] expv,
                            output logic [7:0] frac, output logic sat, output int lat);
        int a, p, norm, fr, ex;
        a = x[15] ? 65536 - int'(x) : int'(x);
        sign = 1'b0; expv = 4'h0; frac = 8'h00; sat = 1'b0; lat = 2;
        if (a == 32768) begin
            sign = 1'b1; expv = 4'hF; frac = 8'hFF; sat = 1'b1;
        end else if (a != 0) begin
            p = 0;
            for (int i = 0; i < 15; i++) begin
                if (a >= (1 << i)) p = i;
            end
            norm = a * (1 << (15 - p));
            fr   = norm / 256;
            ex   = p + 1;
            lat  = 2 + (15 - p);
`ifdef INT_TO_FP_ROUND_EN
            if ((norm / 128) % 2 == 1) begin
                fr++;
                if (fr == 256) begin
                    fr = 128;
                    ex++;
                end
                if (ex == 16) begin
                    fr = 255; ex = 15; sat = 1'b1;
                end
            end
`endif
            sign = x[15];
            expv = ex[3:0];
            frac = fr[7:0];
        end
    endtask

    // Issues one start from an IDLE cycle and waits (bounded) for done_tick.
    task automatic applyStimulus(input logic [15:0] din, output int lat, output bit ready_low_ok);
        intf.start  = 1'b1;
        intf.int_in = din;
        @(posedge clk); #1;
        intf.start  = 1'b0;
        intf.int_in = 16'($urandom);
        lat = 1;
        ready_low_ok = 1'b1;
        while (!intf.done_tick && lat < 40) begin
            if (intf.ready) ready_low_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (intf.ready) ready_low_ok = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic sign, input logic [3:0] expv,
                               input logic [7:0] frac, input logic sat, input int lat_exp,
                               input int lat_act, input bit ready_low_ok);
        check({tag, " latency"}, lat_act, lat_exp);
        check({tag, " done_tick"}, int'(intf.done_tick), 1);
        check({tag, " sign"}, int'(intf.sign_out), int'(sign));
        check({tag, " exp"}, int'(intf.exp_out), int'(expv));
        check({tag, " frac"}, int'(intf.frac_out), int'(frac));
        check({tag, " sat"}, int'(intf.sat_out), int'(sat));
        check({tag, " ready low while busy"}, int'(ready_low_ok), 1);
        @(posedge clk); #1;
        check({tag, " ready after done"}, int'(intf.ready), 1);
        check({tag, " done_tick single"}, int'(intf.done_tick), 0);
    endtask

    initial begin
        vec_t        vecs[9];
        int          lat, done_at, ready_at, extra_done, ready_low_cnt;
        bit          rdy_ok;
        logic        r_sign, r_sat;
        logic [3:0]  r_exp, r_expv_cap;
        logic [7:0]  r_frac, r_frac_cap;
        logic [15:0] din;

        vecs[0] = '{16'h0000, 1'b0, 4'h0, 8'h00, 1'b0, 2};
        vecs[1] = '{16'h0001, 1'b0, 4'h1, 8'h80, 1'b0, 17};
        vecs[2] = '{16'hFFFD, 1'b1, 4'h2, 8'hC0, 1'b0, 16};
        vecs[3] = '{16'h8000, 1'b1, 4'hF, 8'hFF, 1'b1, 2};
`ifdef INT_TO_FP_ROUND_EN
        vecs[4] = '{16'h7FFF, 1'b0, 4'hF, 8'hFF, 1'b1, 3};
        vecs[5] = '{16'h01FF, 1'b0, 4'hA, 8'h80, 1'b0, 9};
`else
        vecs[4] = '{16'h7FFF, 1'b0, 4'hF, 8'hFF, 1'b0, 3};
        vecs[5] = '{16'h01FF, 1'b0, 4'h9, 8'hFF, 1'b0, 9};
`endif
        vecs[6] = '{16'hFFFF, 1'b1, 4'h1, 8'h80, 1'b0, 17};
        vecs[7] = '{16'h4000, 1'b0, 4'hF, 8'h80, 1'b0, 3};
        vecs[8] = '{16'hFF00, 1'b1, 4'h9, 8'h80, 1'b0, 9};

        reset       = 1'b1;
        intf.start  = 1'b0;
        intf.int_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", int'(intf.ready), 1);
        check("reset done_tick", int'(intf.done_tick), 0);
        check("reset sign", int'(intf.sign_out), 0);
        check("reset exp", int'(intf.exp_out), 0);
        check("reset frac", int'(intf.frac_out), 0);
        check("reset sat", int'(intf.sat_out), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].din, lat, rdy_ok);
            checkOutput($sformatf("vec%0d(%h)", i, vecs[i].din), vecs[i].sign, vecs[i].expv,
                        vecs[i].frac, vecs[i].sat, vecs[i].lat, lat, rdy_ok);
        end

        // A start pulse in the middle of a conversion must be dropped, not queued
        intf.start  = 1'b1;
        intf.int_in = 16'h0001;
        @(posedge clk); #1;
        intf.start = 1'b0;
        done_at = -1; ready_at = -1; extra_done = 0;
        r_expv_cap = 4'h0; r_frac_cap = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                intf.start  = 1'b1;
                intf.int_in = 16'h4000;
            end
            if (c == 6) intf.start = 1'b0;
            if (intf.done_tick && done_at < 0) begin
                done_at    = c;
                r_expv_cap = intf.exp_out;
                r_frac_cap = intf.frac_out;
            end else if (intf.done_tick) begin
                extra_done++;
            end
            if (intf.ready && ready_at < 0) ready_at = c;
            @(posedge clk); #1;
        end
        check("ignored start done cycle", done_at, 17);
        check("ignored start ready cycle", ready_at, 18);
        check("ignored start extra done", extra_done, 0);
        check("ignored start exp", int'(r_expv_cap), 1);
        check("ignored start frac", int'(r_frac_cap), 8'h80);

        // Reset in the middle of a conversion clears everything and suppresses done_tick
        intf.start  = 1'b1;
        intf.int_in = 16'h0001;
        @(posedge clk); #1;
        intf.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check("mid reset ready", int'(intf.ready), 1);
        check("mid reset done_tick", int'(intf.done_tick), 0);
        check("mid reset exp", int'(intf.exp_out), 0);
        check("mid reset frac", int'(intf.frac_out), 0);
        check("mid reset sign", int'(intf.sign_out), 0);
        check("mid reset sat", int'(intf.sat_out), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        extra_done = 0; ready_low_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (intf.done_tick) extra_done++;
            if (!intf.ready) ready_low_cnt++;
            @(posedge clk); #1;
        end
        check("post reset done count", extra_done, 0);
        check("post reset ready low cycles", ready_low_cnt, 0);

        // Random operands, mostly back-to-back, spread over all magnitudes
        for (int n = 0; n < 200; n++) begin
            din = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) din = -din;
            if ($urandom_range(0, 19) == 0) din = 16'h0000;
            if ($urandom_range(0, 29) == 0) din = 16'h8000;
            refModel(din, r_sign, r_exp, r_frac, r_sat, done_at);
            applyStimulus(din, lat, rdy_ok);
            checkOutput($sformatf("rand%0d(%h)", n, din), r_sign, r_exp, r_frac, r_sat,
                        done_at, lat, rdy_ok);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
